// File: rtl/weight_loader_pkg.sv
// Shared types for the weight loader: byte lanes, FSM states and the row tag
// that travels alongside each buffer read.
package weight_loader_pkg;

    localparam int BYTE_WIDTH           = 8;
    localparam int WEIGHT_ADDRESS_WIDTH = 24;

    typedef logic [BYTE_WIDTH-1:0] byte_type;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} weight_loader_state_type;

    // valid must stay the MSB: the delay line uses the top bit as its occupancy flag.
    typedef struct packed {
        logic     valid;
        byte_type k;
        logic     zero;
    } row_tag_type;

    function automatic byte_type clamp_rows(input byte_type n, input int unsigned mw);
        return (n == '0 || 32'(n) > mw) ? byte_type'(mw) : n;
    endfunction

endpackage

// File: rtl/weight_loader_if.sv
// Instruction, weight-buffer and MMU-facing signals of the weight loader.
interface weight_loader_if #(
    parameter int MATRIX_WIDTH      = 14,
    parameter int WEIGHT_ADDR_WIDTH = 24
);
    import weight_loader_pkg::*;

    logic                                instr_valid;
    logic                                instr_ready;
    logic [WEIGHT_ADDR_WIDTH-1:0]        instr_base_addr;
    byte_type                            instr_row_count;
    logic                                instr_signed;
    logic                                instr_activate;
    logic                                buf_en;
    logic [WEIGHT_ADDR_WIDTH-1:0]        buf_addr;
    byte_type [MATRIX_WIDTH-1:0]         buf_data;
    byte_type [MATRIX_WIDTH-1:0]         weight_data;
    logic                                weight_signed;
    logic                                load_weight;
    byte_type                            weight_addr;
    logic                                activate_weight;
    logic                                busy;
    logic                                done;

    modport master (
        input  instr_valid, instr_base_addr, instr_row_count, instr_signed, instr_activate,
               buf_data,
        output instr_ready, buf_en, buf_addr, weight_data, weight_signed, load_weight,
               weight_addr, activate_weight, busy, done
    );

    modport slave (
        output instr_valid, instr_base_addr, instr_row_count, instr_signed, instr_activate,
               buf_data,
        input  instr_ready, buf_en, buf_addr, weight_data, weight_signed, load_weight,
               weight_addr, activate_weight, busy, done
    );

endinterface

// File: rtl/weight_loader_enable_delay_line.sv
// Fixed-depth shift register that only advances when en is high; rst clears it.
module enable_delay_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             inner_valid
);

    logic [DEPTH-1:0][WIDTH-1:0] stage;

    always_ff @(posedge clk) begin
        if (rst) begin
            stage <= '0;
        end else if (en) begin
            stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign q = stage[DEPTH-1];

    // Occupancy of every stage except the output one: once these are empty,
    // the entry now at the output is the last one in flight.
    always_comb begin
        inner_valid = 1'b0;
        for (int i = 0; i < DEPTH-1; i++) inner_valid = inner_valid | stage[i][WIDTH-1];
    end

endmodule

// File: rtl/weight_loader.sv
// Streams one weight tile from the weight buffer into the MMU, one row per
// enabled cycle, zero-filling rows beyond the instruction's row count.
module weight_loader
    import weight_loader_pkg::*;
#(
    parameter int MATRIX_WIDTH      = 14,
    parameter int READ_LATENCY      = 1,
    parameter int WEIGHT_ADDR_WIDTH = WEIGHT_ADDRESS_WIDTH
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           enable,
    weight_loader_if.master bus
);

    localparam byte_type K_LAST = byte_type'(MATRIX_WIDTH - 1);
    localparam int       TAG_W  = $bits(row_tag_type);

    weight_loader_state_type      state;
    byte_type                     k;
    byte_type                     cnt;
    logic [WEIGHT_ADDR_WIDTH-1:0] base;
    logic                         act_q;
    logic                         sgn_q;

    row_tag_type tag_in;
    row_tag_type tag_out;
    logic        inner_valid;
    logic        load;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            k     <= '0;
            cnt   <= '0;
            base  <= '0;
            act_q <= 1'b0;
            sgn_q <= 1'b0;
        end else if (enable) begin
            case (state)
                IDLE: begin
                    if (bus.instr_valid) begin
                        base  <= bus.instr_base_addr;
                        cnt   <= clamp_rows(bus.instr_row_count, MATRIX_WIDTH);
                        sgn_q <= bus.instr_signed;
                        act_q <= bus.instr_activate;
                        k     <= '0;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    k <= k + 8'd1;
                    if (k == K_LAST) state <= DRAIN;
                end
                DRAIN:   if (!inner_valid) state <= FINISH;
                FINISH:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Every row index is pushed, including zero-fill ones, so a short load
    // still overwrites all MMU rows.
    always_comb begin
        tag_in = '0;
        if (state == ISSUE) begin
            tag_in.valid = 1'b1;
            tag_in.k     = k;
            tag_in.zero  = (k >= cnt);
        end
    end

    enable_delay_line #(
        .DEPTH (READ_LATENCY),
        .WIDTH (TAG_W)
    ) u_tag_dl (
        .clk         (clk),
        .rst         (rst),
        .en          (enable),
        .d           (tag_in),
        .q           (tag_out),
        .inner_valid (inner_valid)
    );

    assign load = enable && tag_out.valid;

    assign bus.instr_ready     = (state == IDLE) && !rst;
    assign bus.busy            = (state != IDLE);
    assign bus.buf_en          = enable && (state == ISSUE) && (k < cnt);
    assign bus.buf_addr        = bus.buf_en ? base + WEIGHT_ADDR_WIDTH'(k) : '0;
    assign bus.load_weight     = load;
    assign bus.weight_addr     = load ? tag_out.k : '0;
    assign bus.weight_data     = (load && !tag_out.zero) ? bus.buf_data : '0;
    assign bus.weight_signed   = sgn_q;
    assign bus.done            = enable && (state == FINISH);
    assign bus.activate_weight = enable && (state == FINISH) && act_q;

endmodule

// File: tb/tb_weight_loader.sv
// Bench for weight_loader with MATRIX_WIDTH=4, READ_LATENCY=2: timeline masks
// per scenario plus a row scoreboard fed at instruction accept.
module tb_weight_loader;

    logic clk = 1'b0;
    logic rst;
    logic enable;

    always #5 clk = ~clk;

    weight_loader_if #(.MATRIX_WIDTH(4), .WEIGHT_ADDR_WIDTH(24)) wl();

    weight_loader #(
        .MATRIX_WIDTH      (4),
        .READ_LATENCY      (2),
        .WEIGHT_ADDR_WIDTH (24)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .bus    (wl.master)
    );

    typedef struct {
        logic [7:0]  k;
        logic [31:0] d;
    } exp_t;

    exp_t exp_q[$];
    int   errs   = 0;
    int   checks = 0;

    logic [31:0] en_bits, ld_bits, done_bits, act_bits, rdy_bits;
    logic [23:0] addr_log [32];

    function automatic logic [31:0] rowf(input logic [23:0] a);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[i*8 +: 8] = 8'(a[7:0] * 3 + a[23:16] + i * 29 + 5);
        return r;
    endfunction

    // Weight buffer model: data appears two enabled cycles after buf_en.
    logic [1:0]  p_en;
    logic [23:0] pa0, pa1;
    always @(posedge clk) begin
        if (rst) p_en <= '0;
        else if (enable) begin
            p_en <= {p_en[0], wl.buf_en};
            pa0  <= wl.buf_addr;
            pa1  <= pa0;
        end
    end
    assign wl.buf_data = p_en[1] ? rowf(pa1) : 32'hEEEE_EEEE;

    task automatic push_rows(input logic [23:0] base, input logic [7:0] cnt);
        int n;
        n = (cnt == 0 || cnt > 4) ? 4 : int'(cnt);
        for (int r = 0; r < 4; r++)
            exp_q.push_back('{k: 8'(r), d: (r < n) ? rowf(base + 24'(r)) : 32'h0});
    endtask

    always @(posedge clk)
        if (!rst && enable && wl.instr_valid && wl.instr_ready)
            push_rows(wl.instr_base_addr, wl.instr_row_count);

    always @(negedge clk) begin
        exp_t e;
        checks++;
        if (wl.load_weight) begin
            if (exp_q.size() == 0) begin
                errs++;
                $display("FAIL row_unexpected got addr=%0d data=%h, required none", wl.weight_addr, wl.weight_data);
            end else begin
                e = exp_q.pop_front();
                if (wl.weight_addr !== e.k || wl.weight_data !== e.d) begin
                    errs++;
                    $display("FAIL row got addr=%0d data=%h, required addr=%0d data=%h",
                             wl.weight_addr, wl.weight_data, e.k, e.d);
                end
            end
        end else if (wl.weight_data !== '0) begin
            errs++;
            $display("FAIL idle_data got %h, required 0", wl.weight_data);
        end
    end

    task automatic issue(input logic [23:0] base, input logic [7:0] cnt, input logic sg, input logic act);
        wl.instr_base_addr = base;
        wl.instr_row_count = cnt;
        wl.instr_signed    = sg;
        wl.instr_activate  = act;
        wl.instr_valid     = 1'b1;
    endtask

    // Cycle 0 is the accept cycle; records cycles 0..n.
    task automatic capture(input int n, input logic [31:0] stall, input logic keep, input logic [23:0] base_after);
        en_bits = '0; ld_bits = '0; done_bits = '0; act_bits = '0; rdy_bits = '0;
        for (int c = 0; c <= n; c++) begin
            enable = !stall[c];
            @(negedge clk);
            en_bits[c]   = wl.buf_en;
            ld_bits[c]   = wl.load_weight;
            done_bits[c] = wl.done;
            act_bits[c]  = wl.activate_weight;
            rdy_bits[c]  = wl.instr_ready;
            addr_log[c]  = wl.buf_addr;
            @(posedge clk); #1;
            if (c == 0) begin
                if (keep) wl.instr_base_addr = base_after;
                else      wl.instr_valid = 1'b0;
            end
        end
        enable = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1; enable = 1'b1; wl.instr_valid = 1'b0;
        wl.instr_base_addr = '0; wl.instr_row_count = '0; wl.instr_signed = 1'b0; wl.instr_activate = 1'b0;
        repeat (2) @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (wl.instr_ready !== 1'b0) begin errs++; $display("FAIL reset_ready got %b, required 0", wl.instr_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({wl.buf_en, wl.buf_addr, wl.weight_data, wl.weight_signed, wl.load_weight, wl.weight_addr,
             wl.activate_weight, wl.busy, wl.done} !== '0) begin
            errs++; $display("FAIL reset_outputs got nonzero (busy=%b buf_en=%b), required 0", wl.busy, wl.buf_en);
        end
        checks++;
        if (wl.instr_ready !== 1'b1) begin errs++; $display("FAIL reset_ready_after got %b, required 1", wl.instr_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_full_load;
        issue(24'h10, 8'd4, 1'b1, 1'b1);
        capture(8, 32'h0, 1'b0, 24'h0);
        checks++; if (en_bits[8:0] !== 9'h01E) begin errs++; $display("FAIL full_buf_en got %h, required 01e", en_bits[8:0]); end
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if (addr_log[i] !== 24'h10 + 24'(i - 1)) begin
                errs++; $display("FAIL full_addr[%0d] got %h, required %h", i, addr_log[i], 24'h10 + 24'(i - 1));
            end
        end
        checks++; if (ld_bits[8:0] !== 9'h078) begin errs++; $display("FAIL full_load got %h, required 078", ld_bits[8:0]); end
        checks++; if (done_bits[8:0] !== 9'h080) begin errs++; $display("FAIL full_done got %h, required 080", done_bits[8:0]); end
        checks++; if (act_bits[8:0] !== 9'h080) begin errs++; $display("FAIL full_act got %h, required 080", act_bits[8:0]); end
        checks++; if (rdy_bits[8:0] !== 9'h101) begin errs++; $display("FAIL full_ready got %h, required 101", rdy_bits[8:0]); end
        checks++; if (wl.weight_signed !== 1'b1) begin errs++; $display("FAIL full_signed got %b, required 1", wl.weight_signed); end
        checks++; if (exp_q.size() != 0) begin errs++; $display("FAIL full_rows_left got %0d, required 0", exp_q.size()); end
    endtask

    task automatic test_short_load;
        issue(24'h40, 8'd2, 1'b0, 1'b0);
        capture(8, 32'h0, 1'b0, 24'h0);
        checks++; if (en_bits[8:0] !== 9'h006) begin errs++; $display("FAIL short_buf_en got %h, required 006", en_bits[8:0]); end
        checks++; if (ld_bits[8:0] !== 9'h078) begin errs++; $display("FAIL short_load got %h, required 078", ld_bits[8:0]); end
        checks++; if (done_bits[8:0] !== 9'h080) begin errs++; $display("FAIL short_done got %h, required 080", done_bits[8:0]); end
        checks++; if (act_bits[8:0] !== 9'h000) begin errs++; $display("FAIL short_act got %h, required 000", act_bits[8:0]); end
        checks++; if (wl.weight_signed !== 1'b0) begin errs++; $display("FAIL short_signed got %b, required 0", wl.weight_signed); end
        checks++; if (exp_q.size() != 0) begin errs++; $display("FAIL short_rows_left got %0d, required 0", exp_q.size()); end
    endtask

    task automatic test_stall;
        issue(24'h80, 8'd4, 1'b1, 1'b0);
        capture(11, 32'h1C, 1'b0, 24'h0);
        checks++; if (en_bits[11:0] !== 12'h0E2) begin errs++; $display("FAIL stall_buf_en got %h, required 0e2", en_bits[11:0]); end
        checks++; if (ld_bits[11:0] !== 12'h3C0) begin errs++; $display("FAIL stall_load got %h, required 3c0", ld_bits[11:0]); end
        checks++; if (done_bits[11:0] !== 12'h400) begin errs++; $display("FAIL stall_done got %h, required 400", done_bits[11:0]); end
        checks++; if (rdy_bits[11:0] !== 12'h801) begin errs++; $display("FAIL stall_ready got %h, required 801", rdy_bits[11:0]); end
        checks++; if (exp_q.size() != 0) begin errs++; $display("FAIL stall_rows_left got %0d, required 0", exp_q.size()); end
    endtask

    task automatic test_wrap_clamp;
        logic [23:0] ea;
        issue(24'hFFFFFE, 8'd9, 1'b0, 1'b0);
        capture(8, 32'h0, 1'b0, 24'h0);
        checks++; if (en_bits[8:0] !== 9'h01E) begin errs++; $display("FAIL wrap_buf_en got %h, required 01e", en_bits[8:0]); end
        for (int i = 1; i <= 4; i++) begin
            ea = 24'hFFFFFE + 24'(i - 1);
            checks++;
            if (addr_log[i] !== ea) begin errs++; $display("FAIL wrap_addr[%0d] got %h, required %h", i, addr_log[i], ea); end
        end
        issue(24'h20, 8'd0, 1'b0, 1'b0);
        capture(8, 32'h0, 1'b0, 24'h0);
        checks++; if (en_bits[8:0] !== 9'h01E) begin errs++; $display("FAIL zero_cnt_buf_en got %h, required 01e", en_bits[8:0]); end
        checks++; if (ld_bits[8:0] !== 9'h078) begin errs++; $display("FAIL zero_cnt_load got %h, required 078", ld_bits[8:0]); end
        checks++; if (exp_q.size() != 0) begin errs++; $display("FAIL wrap_rows_left got %0d, required 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid;
        issue(24'h10, 8'd4, 1'b1, 1'b1);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            wl.instr_valid = 1'b0;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({wl.buf_en, wl.buf_addr, wl.weight_data, wl.weight_signed, wl.load_weight, wl.weight_addr,
             wl.activate_weight, wl.busy, wl.done} !== '0) begin
            errs++; $display("FAIL midrst_outputs got nonzero (busy=%b load=%b), required 0", wl.busy, wl.load_weight);
        end
        checks++; if (wl.instr_ready !== 1'b1) begin errs++; $display("FAIL midrst_ready got %b, required 1", wl.instr_ready); end
        exp_q.delete();
        @(posedge clk); #1;
        issue(24'h10, 8'd4, 1'b1, 1'b1);
        capture(8, 32'h0, 1'b0, 24'h0);
        checks++; if (en_bits[8:0] !== 9'h01E) begin errs++; $display("FAIL midrst_buf_en got %h, required 01e", en_bits[8:0]); end
        checks++; if (ld_bits[8:0] !== 9'h078) begin errs++; $display("FAIL midrst_load got %h, required 078", ld_bits[8:0]); end
        checks++; if (done_bits[8:0] !== 9'h080) begin errs++; $display("FAIL midrst_done got %h, required 080", done_bits[8:0]); end
        checks++; if (exp_q.size() != 0) begin errs++; $display("FAIL midrst_rows_left got %0d, required 0", exp_q.size()); end
    endtask

    task automatic test_back_to_back;
        bit seen;
        issue(24'h100, 8'd4, 1'b0, 1'b0);
        capture(9, 32'h0, 1'b1, 24'h200);
        wl.instr_valid = 1'b0;
        checks++; if (rdy_bits[9:0] !== 10'h101) begin errs++; $display("FAIL b2b_ready got %h, required 101", rdy_bits[9:0]); end
        checks++; if (en_bits[9:0] !== 10'h21E) begin errs++; $display("FAIL b2b_buf_en got %h, required 21e", en_bits[9:0]); end
        checks++; if (addr_log[1] !== 24'h100) begin errs++; $display("FAIL b2b_first_addr got %h, required 000100", addr_log[1]); end
        checks++; if (addr_log[9] !== 24'h200) begin errs++; $display("FAIL b2b_second_addr got %h, required 000200", addr_log[9]); end
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = wl.instr_ready;
        end
        checks++; if (!seen) begin errs++; $display("FAIL b2b_drain got timeout, required instr_ready within 40 cycles"); end
        checks++; if (exp_q.size() != 0) begin errs++; $display("FAIL b2b_rows_left got %0d, required 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_short_load();
        test_stall();
        test_wrap_clamp();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout, required completion");
        $fatal(1);
    end

endmodule

// File: doc/weight_loader.md
# weight_loader

Sequences one weight-tile load into `matrix_multiply_unit`. It accepts a load instruction, reads MATRIX_WIDTH rows from the weight buffer, and presents them one row per cycle on the MMU's `weight_data`/`load_weight`/`weight_addr` inputs. Once all rows are in, it can optionally pulse `activate_weight`. The block sits between the instruction dispatcher and the weight buffer on one side and the matrix multiply unit on the other.

## Interface
- MATRIX_WIDTH, 14, systolic array dimension; bytes per weight row.
- READ_LATENCY, 1, weight buffer read latency in enabled cycles; legal range 1..4.
- WEIGHT_ADDR_WIDTH, 24, weight buffer address width.
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  global advance; when low, the block and its weight buffer read pipeline hold.
- instr_valid  in  1  load instruction present.
- instr_ready  out  1  high in IDLE and not in reset; an instruction is accepted when `instr_valid && instr_ready && enable`.
- instr_base_addr  in  WEIGHT_ADDR_WIDTH  buffer address of row 0.
- instr_row_count  in  8  number of rows to read; 0 or >MATRIX_WIDTH is treated as MATRIX_WIDTH.
- instr_signed  in  1  weights are signed.
- instr_activate  in  1  pulse `activate_weight` after the load.
- buf_en  out  1  buffer read strobe.
- buf_addr  out  WEIGHT_ADDR_WIDTH  buffer read address.
- buf_data  in  byte_type[MATRIX_WIDTH]  read data, valid READ_LATENCY enabled cycles after `buf_en`.
- weight_data  out  byte_type[MATRIX_WIDTH]  row to the MMU.
- weight_signed  out  1  registered `instr_signed`.
- load_weight  out  1  row strobe to the MMU.
- weight_addr  out  byte_type  destination row index.
- activate_weight  out  1  one-cycle activate pulse.
- busy  out  1  state ≠ IDLE.
- done  out  1  one-cycle completion pulse.

## Operation
- States:
  - IDLE: on accept, latch base, clamped count, signed and activate; `weight_signed` updates; go to ISSUE.
  - ISSUE: counter k = 0..MATRIX_WIDTH-1, one step per enabled cycle.
    - k < count: `buf_en`=1, `buf_addr` = base+k mod 2^WEIGHT_ADDR_WIDTH.
    - k ≥ count: `buf_en`=0 and the row is tagged zero-fill.
    - Every k pushes {valid, k, zero} into a READ_LATENCY-deep delay line.
    - After k = MATRIX_WIDTH-1, go to DRAIN.
  - DRAIN: wait until the delay line is empty, then go to FINISH.
  - FINISH: one cycle. `done`=1; `activate_weight`=latched activate; go to IDLE.
- Delay-line output valid ⇒ `load_weight`=1, `weight_addr`=k, `weight_data` = zero ? 0 : `buf_data`.
- All MATRIX_WIDTH rows are always written, so no stale weights survive a short load.
- `weight_data` is 0 whenever `load_weight`=0.
- enable low: state, counter and delay line hold; `buf_en`, `load_weight`, `activate_weight` and `done` are forced 0; rows are neither dropped nor duplicated.
- `instr_valid` during busy: not accepted and left pending; no error.
- rst (including mid-load): state IDLE, delay line cleared. In-flight rows are lost; already-loaded MMU rows are not retracted.

## Timing
- Reset values: `buf_en`, `buf_addr`, `weight_data`, `weight_signed`, `load_weight`, `weight_addr`, `activate_weight`, `busy`, `done` are all 0. `instr_ready` is 0 while rst=1.
- With accept at cycle T and enable held high:
  - `buf_en` rows: T+1 .. T+MATRIX_WIDTH.
  - `load_weight`: T+1+READ_LATENCY .. T+MATRIX_WIDTH+READ_LATENCY.
  - `done` / `activate_weight`: T+MATRIX_WIDTH+READ_LATENCY+1.
  - `instr_ready`: T+MATRIX_WIDTH+READ_LATENCY+2.
- Back-to-back instructions therefore have a period of MATRIX_WIDTH+READ_LATENCY+2.
- Each enable-low cycle adds one cycle to every subsequent event.

## Structure
- Into tpu_pkg: `byte_type`, `BYTE_WIDTH`, `WEIGHT_ADDRESS_WIDTH`, and the enum `weight_loader_state_type` {IDLE, ISSUE, DRAIN, FINISH}.
- One sub-module: `enable_delay_line`, parameterised by DEPTH and WIDTH, enable-gated with synchronous clear. It carries {valid, k, zero}.

## Test plan
All scenarios use MATRIX_WIDTH=4, READ_LATENCY=2, WEIGHT_ADDR_WIDTH=24.
- Full load: base 0x10, count 4, signed 1, activate 1 accepted at cycle 0 → `buf_addr` 0x10..0x13 at cycles 1-4; `load_weight` at cycles 3-6 with `weight_addr` 0..3 and matching buffer rows; `activate_weight`, `done` at cycle 7; `instr_ready` at 8; `weight_signed`=1.
- Short load: count 2, activate 0 → `buf_en` at cycles 1-2 only; rows 2,3 loaded as all-zero at cycles 5-6; `done` at 7; `activate_weight` never asserts.
- Stall: enable low for cycles 2-4 → `load_weight` at cycles 6-9; `done` at 10; each row exactly once, with correct data.
- Wrap and clamp: base 0xFFFFFE, count 9 → addresses 0xFFFFFE, 0xFFFFFF, 0x000000, 0x000001; four rows read. count 0 → also four rows read.
- Reset mid-load: rst at cycle 4 → cycle 5 has all outputs 0 and `busy`=0; `instr_ready`=1 after rst falls; a new instruction then follows the full-load timeline.
- Busy hold-off: `instr_valid` held from cycle 1 → second accept at cycle 8 exactly, with the new base used.
